ticket_fifo_ctrl: RTL and testbench

TICKET_FIFO_CTRL -- requirements
Module: ticket_fifo_ctrl

---
 rtl/ticket_fifo_if.sv | 31 +++
 rtl/ticket_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_ticket_fifo_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ticket_fifo_if.sv
// ticket_fifo_if -- streaming and RAM-port bundle for ticket_fifo_ctrl.
//   in_valid/in_data/in_ready     upstream ticket handshake
//   out_valid/out_data/out_ready  downstream ticket handshake
//   ram_we/ram_waddr/ram_wdata    external RAM write port
//   ram_raddr/ram_q               external RAM read port (q registered, 1-cycle)
// master: the controller side. slave: the environment (source, sink, RAM).
interface ticket_fifo_if #(
  parameter int DATA_WIDTH = 68,
  parameter int ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    input  in_valid, in_data, out_ready, ram_q,
    output in_ready, out_valid, out_data, ram_we, ram_waddr, ram_wdata, ram_raddr
  );
  modport slave (
    output in_valid, in_data, out_ready, ram_q,
    input  in_ready, out_valid, out_data, ram_we, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/ticket_fifo_ctrl.sv
// ticket_fifo_ctrl -- FIFO controller around an external synchronous RAM with a
// 1-cycle registered read, plus a 2-entry output stage so the downstream side
// sees one ticket per cycle despite the RAM read latency.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          ticket_fifo_if.master (in/out handshakes and RAM ports)
//   level        tickets held: RAM + in-flight read + output stage
//   hwm          high-water mark of level
//   hwm_clr      synchronous high-water-mark clear (loads current level)
// Optional feature: define TICKET_FIFO_CTRL_HWM_EN to build the high-water-mark
// register; otherwise hwm is tied to zero and hwm_clr is ignored.
module ticket_fifo_ctrl #(
  parameter int DATA_WIDTH = 68,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ticket_fifo_if.master         bus,
  input  logic                  hwm_clr,
  output logic [ADDR_WIDTH+1:0] level,
  output logic [ADDR_WIDTH+1:0] hwm
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LW    = ADDR_WIDTH + 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
  logic                  inflight_q, inflight_d;
  logic [1:0]            out_cnt_q, out_cnt_d, cnt_a;
  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic                  ram_full, ram_empty, push, pop, issue;
  logic [2:0]            occ;

  // Extra pointer bit distinguishes full from empty; wrap is plain modulo.
  assign ram_cnt   = wr_ptr_q - rd_ptr_q;
  assign ram_full  = (ram_cnt == PW'(DEPTH));
  assign ram_empty = (ram_cnt == '0);

  assign bus.in_ready  = !ram_full;
  assign bus.out_valid = (out_cnt_q != 2'd0);
  assign bus.out_data  = head_q;

  assign push = bus.in_valid && !ram_full;
  assign pop  = bus.out_valid && bus.out_ready;

  // Only read when the output stage can still hold the result after this
  // cycle's pop, counting the read already in flight.
  assign occ   = {1'b0, out_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = !ram_empty && (occ < 3'd2);

  assign bus.ram_we    = push;
  assign bus.ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_wdata = bus.in_data;
  assign bus.ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];

  assign level = LW'(ram_cnt) + LW'(inflight_q) + LW'(out_cnt_q);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(issue);
    inflight_d = issue;
    // Pop first, then append the returning read behind whatever remains.
    cnt_a      = out_cnt_q - {1'b0, pop};
    head_d     = pop ? skid_q : head_q;
    skid_d     = skid_q;
    if (inflight_q) begin
      if (cnt_a == 2'd0) head_d = bus.ram_q;
      else               skid_d = bus.ram_q;
    end
    out_cnt_d  = cnt_a + {1'b0, inflight_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

`ifdef TICKET_FIFO_CTRL_HWM_EN
  logic [LW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr)           hwm_d = level;
    else if (level > hwm_q) hwm_d = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  logic unused_hwm_clr;
  assign unused_hwm_clr = hwm_clr;
  assign hwm = '0;
`endif
endmodule

// File: tb/tb_ticket_fifo_ctrl.sv
// Bench for ticket_fifo_ctrl: behavioural RAM, negedge scoreboard monitor,
// directed scenarios for latency, fill, streaming, reset and high-water mark.
module tb_ticket_fifo_ctrl;
  localparam int DW = 68;
  localparam int AW = 4;
  localparam int LW = AW + 2;
`ifdef TICKET_FIFO_CTRL_HWM_EN
  localparam int HWM_PEAK = 9;
  localparam int HWM_CLR  = 2;
`else
  localparam int HWM_PEAK = 0;
  localparam int HWM_CLR  = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hwm_clr = 1'b0;
  logic [LW-1:0] level, hwm;

  ticket_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ticket_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .hwm_clr (hwm_clr),
    .level   (level),
    .hwm     (hwm)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with registered read.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_raddr];
  end

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop  = 0;
  int id     = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int n);
    return {4'hC, 32'(n) ^ 32'hA5A5_0000, 32'(n)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable from posedge+1 until the next posedge, so
  // handshakes seen at negedge are exactly those the next edge completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra got %0h want none", bus.out_data);
        end else begin
          chk("sb_data", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        n_push++;
      end
      if (!bus.in_ready) chk("we_when_full", bus.ram_we, 0);
    end
  end

  task automatic push_k(input int k);
    int   got = 0;
    logic acc;
    for (int c = 0; c < 200 && got < k; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = mk(id);
      acc = bus.in_ready;
      step();
      if (acc) begin got++; id++; end
    end
    bus.in_valid = 1'b0;
    chk("push_k_count", got, k);
  endtask

  task automatic drain(input int max);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < max && level != 0; c++) step();
    chk("drain_level", level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   got, p0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_hwm", hwm, 0);

    // Single ticket latency: accepted at edge t0, visible after edge t0+2
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(5);
    #1;
    chk("lat_ram_we", bus.ram_we, 1);
    chk("lat_waddr", bus.ram_waddr, 0);
    chk("lat_wdata", bus.ram_wdata, 5);
    step();
    bus.in_valid = 1'b0;
    chk("lat_t0_valid", bus.out_valid, 0);
    chk("lat_t0_level", level, 1);
    step();
    chk("lat_t1_valid", bus.out_valid, 0);
    step();
    chk("lat_t2_valid", bus.out_valid, 1);
    chk("lat_t2_data", bus.out_data, 5);
    step();
    chk("lat_t3_level", level, 0);
    chk("lat_t3_valid", bus.out_valid, 0);

    // Fill: 20 back-to-back attempts with the sink stalled -> 18 accepted
    bus.out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = mk(id);
      acc = bus.in_ready;
      step();
      if (acc) begin got++; id++; end
    end
    chk("fill_accepted", got, 18);
    chk("fill_level", level, 18);
    chk("fill_in_ready", bus.in_ready, 0);

    // Stream from full. in_ready comes from registered fullness, so the first
    // cycle only pops; after that push and pop complete every cycle at 17.
    bus.out_ready = 1'b1;
    p0 = n_pop;
    step();
    chk("stream_first_level", level, 17);
    for (int i = 0; i < 8; i++) begin
      bus.in_data = mk(id);
      acc = bus.in_ready;
      step();
      if (acc) id++;
      chk("stream_accept", acc, 1);
      chk("stream_level", level, 17);
    end
    chk("stream_pops", n_pop - p0, 9);
    drain(100);

    // Random stream of 100 tickets
    got = 0;
    for (int c = 0; c < 3000 && got < 100; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = mk(id);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin got++; id++; end
    end
    chk("rand_accepted", got, 100);
    drain(200);
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_push_pop", n_pop, n_push);

    // Reset mid-operation at level 7 with a read in flight
    bus.out_ready = 1'b0;
    push_k(7);
    repeat (3) step();
    chk("mid_level_pre", level, 7);
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(id);
    bus.out_ready = 1'b1;
    step();
    id++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("mid_level", level, 7);
    chk("mid_inflight", dut.inflight_q, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_level", level, 0);
    step();
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(id);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("post_rst_t1_valid", bus.out_valid, 0);
    step();
    chk("post_rst_t2_valid", bus.out_valid, 1);
    chk("post_rst_t2_data", bus.out_data, mk(id));
    id++;
    step();
    chk("post_rst_level", level, 0);

    // High-water mark: fill to 9, drain to 2, clear
    bus.out_ready = 1'b0;
    push_k(9);
    repeat (3) step();
    chk("hwm_fill_level", level, 9);
    chk("hwm_peak", hwm, HWM_PEAK);
    bus.out_ready = 1'b1;
    repeat (7) step();
    bus.out_ready = 1'b0;
    chk("hwm_drain_level", level, 2);
    step();
    chk("hwm_hold", hwm, HWM_PEAK);
    hwm_clr = 1'b1;
    step();
    hwm_clr = 1'b0;
    chk("hwm_cleared", hwm, HWM_CLR);
    drain(20);
    chk("end_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
